ifetch_queue: RTL and testbench



---
 rtl/ifetch_queue_if.sv | 25 ++
 rtl/ifetch_queue.sv | 92 +++++++++
 tb/tb_ifetch_queue.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_queue_if.sv
// Fetch-queue bus: redirect input, instruction-memory request/response and the IF/ID handshake.
// The master modport is the fetch queue; the slave modport is its memory/decode environment.
interface ifetch_queue_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready;

  modport master (
    input  redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid, mem_resp_data, out_ready,
    output mem_req_valid, mem_req_addr, out_valid, out_pc, out_inst
  );

  modport slave (
    output redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid, mem_resp_data, out_ready,
    input  mem_req_valid, mem_req_addr, out_valid, out_pc, out_inst
  );
endinterface

// File: rtl/ifetch_queue.sv
// Decoupled RV32 instruction-fetch queue: credit-limited sequential fetch, in-order response
// buffering into a {pc, inst} FIFO, and redirect flush that drops every pre-redirect response.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  ifetch_queue_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;

  logic          w_credit;
  logic          w_accept;
  logic          w_resp;
  logic          w_push;
  logic          w_pop;
  logic [CW:0]   w_inflight;
  logic [31:0]   w_target;
  logic [1:0]    w_unused_pc_lsb;

  // Credit counts buffered plus outstanding fetches as seen at the start of the cycle.
  assign w_inflight        = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_credit          = w_inflight < (CW + 1)'(DEPTH);

  assign bus.mem_req_valid = !rst && !bus.redirect_valid && w_credit;
  assign bus.mem_req_addr  = r_fetch_pc;
  assign w_accept          = bus.mem_req_valid && bus.mem_req_ready;
  assign w_resp            = bus.mem_resp_valid && (r_outstanding != '0);
  assign w_push            = w_resp && (r_drop == '0) && !bus.redirect_valid;

  assign bus.out_valid     = !rst && (r_count != '0);
  assign w_pop             = bus.out_valid && bus.out_ready && !bus.redirect_valid;
  assign bus.out_pc        = bus.out_valid ? r_mem[r_rd_ptr].pc   : '0;
  assign bus.out_inst      = bus.out_valid ? r_mem[r_rd_ptr].inst : '0;

  assign w_target          = {bus.redirect_pc[31:2], 2'b00};
  assign w_unused_pc_lsb   = bus.redirect_pc[1:0];

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_resp);
      if (bus.redirect_valid) begin
        r_fetch_pc <= w_target;
        r_resp_pc  <= w_target;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_count    <= '0;
        // Everything still in flight after this cycle's response belongs to the old path.
        r_drop     <= r_outstanding - CW'(w_resp);
      end else begin
        if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_resp && (r_drop != '0)) r_drop <= r_drop - CW'(1);
        if (w_push) begin
          r_wr_ptr  <= r_wr_ptr + AW'(1);
          r_resp_pc <= r_resp_pc + 32'd4;
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // NOTE: the entry storage has no reset; out_valid gates every read, so stale contents never escape.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{pc: r_resp_pc, inst: bus.mem_resp_data};
  end
endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: table-driven reset/stream/backpressure vectors, directed
// redirect/wrap/reset corners, and a randomized run against a queue-based reference model.
module tb_ifetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifetch_queue_if bus ();

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory: in-order responses, configurable latency and ready probability.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];
  int    mem_lat   = 1;
  int    ready_pct = 100;

  // Reference model: FIFO of delivered entries and in-flight requests tagged live/stale.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;
  typedef struct {
    logic [31:0] addr;
    bit          live;
  } fl_t;
  ent_t        m_fifo[$];
  fl_t         m_fl[$];
  logic [31:0] m_fetch_pc = RESET_PC;

  task automatic step();
    logic        exp_rv, exp_ov, acc, resp, redir, oready, mready, r;
    logic [31:0] a_addr, rpc;
    fl_t         fl;
    #1;
    r      = rst;
    redir  = bus.redirect_valid;
    rpc    = bus.redirect_pc;
    oready = bus.out_ready;
    mready = bus.mem_req_ready;
    exp_rv = !r && !redir && ((m_fifo.size() + m_fl.size()) < DEPTH);
    exp_ov = !r && (m_fifo.size() != 0);
    check("req_valid", bus.mem_req_valid, exp_rv);
    if (exp_rv) check("req_addr", bus.mem_req_addr, m_fetch_pc);
    check("out_valid", bus.out_valid, exp_ov);
    if (exp_ov) begin
      check("out_pc", bus.out_pc, m_fifo[0].pc);
      check("out_inst", bus.out_inst, m_fifo[0].inst);
    end else if (r) begin
      check("rst_out_pc", bus.out_pc, 32'h0);
      check("rst_out_inst", bus.out_inst, 32'h0);
    end
    acc    = bus.mem_req_valid && bus.mem_req_ready;
    a_addr = bus.mem_req_addr;
    resp   = bus.mem_resp_valid;

    @(posedge clk);
    cyc++;
    if (r) begin
      mq.delete();
    end else begin
      if (resp && mq.size() != 0) void'(mq.pop_front());
      if (acc) mq.push_back('{a_addr, cyc + mem_lat});
    end

    if (r) begin
      m_fifo.delete();
      m_fl.delete();
      m_fetch_pc = RESET_PC;
    end else begin
      if (redir) begin
        m_fifo.delete();
        foreach (m_fl[i]) m_fl[i].live = 1'b0;
      end else if (exp_ov && oready) begin
        void'(m_fifo.pop_front());
      end
      if (resp && m_fl.size() != 0) begin
        fl = m_fl.pop_front();
        if (fl.live) m_fifo.push_back('{fl.addr, word_at(fl.addr)});
      end
      if (redir) begin
        m_fetch_pc = rpc & ~32'h3;
      end else if (exp_rv && mready) begin
        m_fl.push_back('{m_fetch_pc, 1'b1});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end

    @(negedge clk);
    if (mq.size() != 0 && mq[0].due <= cyc + 1) begin
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = word_at(mq[0].addr);
    end else begin
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = $urandom;
    end
    bus.mem_req_ready = ($urandom_range(0, 99) < ready_pct);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  typedef struct {
    bit          rst;
    bit          oready;
    bit          rv;
    logic [31:0] ra;
    bit          ov;
    logic [31:0] opc;
  } vec_t;
  vec_t vq[$];

  function automatic void add_vec(input bit r, input bit o, input bit rv, input logic [31:0] ra,
                                  input bit ov, input logic [31:0] opc);
    vq.push_back('{r, o, rv, ra, ov, opc});
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = 32'h0;
    bus.out_ready      = 1'b0;

    // Streaming from reset: 1-cycle memory, always ready, consumer always ready.
    add_vec(1, 1, 0, 32'h00, 0, 32'h00);
    add_vec(0, 1, 1, 32'h00, 0, 32'h00);
    add_vec(0, 1, 1, 32'h04, 0, 32'h00);
    add_vec(0, 1, 1, 32'h08, 1, 32'h00);
    add_vec(0, 1, 1, 32'h0C, 1, 32'h04);
    add_vec(0, 1, 1, 32'h10, 1, 32'h08);
    add_vec(0, 1, 1, 32'h14, 1, 32'h0C);
    // Backpressure: 10 cycles of out_ready low, then drain and resume at 0x10.
    add_vec(1, 0, 0, 32'h00, 0, 32'h00);
    add_vec(0, 0, 1, 32'h00, 0, 32'h00);
    add_vec(0, 0, 1, 32'h04, 0, 32'h00);
    add_vec(0, 0, 1, 32'h08, 1, 32'h00);
    add_vec(0, 0, 1, 32'h0C, 1, 32'h00);
    for (int i = 0; i < 6; i++) add_vec(0, 0, 0, 32'h00, 1, 32'h00);
    add_vec(0, 1, 0, 32'h00, 1, 32'h00);
    add_vec(0, 1, 1, 32'h10, 1, 32'h04);
    add_vec(0, 1, 1, 32'h14, 1, 32'h08);
    add_vec(0, 1, 1, 32'h18, 1, 32'h0C);
    add_vec(0, 1, 1, 32'h1C, 1, 32'h10);
    add_vec(0, 1, 1, 32'h20, 1, 32'h14);

    foreach (vq[i]) begin
      rst           = vq[i].rst;
      bus.out_ready = vq[i].oready;
      #1;
      check($sformatf("vec%0d_req_valid", i), bus.mem_req_valid, vq[i].rv);
      if (vq[i].rv) check($sformatf("vec%0d_req_addr", i), bus.mem_req_addr, vq[i].ra);
      check($sformatf("vec%0d_out_valid", i), bus.out_valid, vq[i].ov);
      if (vq[i].ov) begin
        check($sformatf("vec%0d_out_pc", i), bus.out_pc, vq[i].opc);
        check($sformatf("vec%0d_out_inst", i), bus.out_inst, word_at(vq[i].opc));
      end
      step();
    end

    // Redirect with two fetches in flight on a 3-cycle memory.
    mem_lat = 3;
    rst = 1'b1; step();
    rst = 1'b0; bus.out_ready = 1'b1;
    cycles(2);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0103;
    #1;
    check("redir_no_req", bus.mem_req_valid, 1'b0);
    step();
    bus.redirect_valid = 1'b0;
    begin : redir_blk
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
        #1;
        if (bus.out_valid) begin
          seen = 1'b1;
          check("redir_first_pc", bus.out_pc, 32'h100);
          check("redir_first_inst", bus.out_inst, word_at(32'h100));
        end
        step();
      end
      check("redir_seen_output", seen, 1'b1);
    end

    // Redirect, response and pop all in the same cycle.
    mem_lat = 1;
    cycles(6);
    begin : simul_blk
      bit found;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
        #1;
        if (bus.mem_resp_valid && bus.out_valid) found = 1'b1;
        else step();
      end
      check("simul_setup", found, 1'b1);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_0200;
      #1;
      check("simul_no_req", bus.mem_req_valid, 1'b0);
      step();
      bus.redirect_valid = 1'b0;
      #1;
      check("simul_empty", bus.out_valid, 1'b0);
      check("simul_next_req", bus.mem_req_valid, 1'b1);
      check("simul_next_addr", bus.mem_req_addr, 32'h200);
      step();
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
        #1;
        if (bus.out_valid) begin
          found = 1'b1;
          check("simul_first_pc", bus.out_pc, 32'h200);
        end
        step();
      end
      check("simul_seen_output", found, 1'b1);
    end

    // Address wrap through 0xFFFF_FFFC.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFB;
    step();
    bus.redirect_valid = 1'b0;
    begin : wrap_blk
      logic [31:0] acc_q[$];
      logic [31:0] out_q[$];
      logic [31:0] wexp[3];
      wexp[0] = 32'hFFFF_FFF8;
      wexp[1] = 32'hFFFF_FFFC;
      wexp[2] = 32'h0000_0000;
      for (int i = 0; i < 20 && (acc_q.size() < 3 || out_q.size() < 3); i++) begin
        #1;
        if (bus.mem_req_valid && bus.mem_req_ready && acc_q.size() < 3) acc_q.push_back(bus.mem_req_addr);
        if (bus.out_valid && bus.out_ready && out_q.size() < 3) out_q.push_back(bus.out_pc);
        step();
      end
      check("wrap_req_count", 32'(acc_q.size()), 32'd3);
      check("wrap_out_count", 32'(out_q.size()), 32'd3);
      for (int i = 0; i < 3; i++) begin
        if (i < acc_q.size()) check($sformatf("wrap_req%0d", i), acc_q[i], wexp[i]);
        if (i < out_q.size()) check($sformatf("wrap_out%0d", i), out_q[i], wexp[i]);
      end
    end

    // Reset with the FIFO full and nothing outstanding.
    bus.out_ready = 1'b0;
    cycles(8);
    #1;
    check("full_out_valid", bus.out_valid, 1'b1);
    check("full_no_req", bus.mem_req_valid, 1'b0);
    rst = 1'b1;
    #1;
    check("rstcyc_out_valid", bus.out_valid, 1'b0);
    check("rstcyc_req_valid", bus.mem_req_valid, 1'b0);
    step();
    rst = 1'b0;
    #1;
    check("postrst_out_valid", bus.out_valid, 1'b0);
    check("postrst_req_valid", bus.mem_req_valid, 1'b1);
    check("postrst_req_addr", bus.mem_req_addr, RESET_PC);
    step();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) begin
        mem_lat   = $urandom_range(1, 4);
        ready_pct = $urandom_range(30, 100);
      end
      rst                = ($urandom_range(0, 999) < 3);
      bus.out_ready      = ($urandom_range(0, 99) < 70);
      bus.redirect_valid = ($urandom_range(0, 99) < 4);
      bus.redirect_pc    = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
